// File: rtl/pattern_fetch_pkg.sv
// pattern_fetch_pkg
//   Shared definitions for the pattern fetcher: controller state encoding,
//   default address/data widths and the depth of the byte buffer that sits
//   between the pattern memory and the LED serializer.
package pattern_fetch_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/pattern_fifo2.sv
// pattern_fifo2
//   Two-entry synchronous FIFO holding fetched pattern bytes.
//   Ports:
//     clk_i        clock
//     rst_n_i      synchronous active-low reset (empties the FIFO, zeroes slots)
//     push_i       write push_data_i at this edge (never issued when full)
//     push_data_i  byte to write
//     pop_i        drop the head entry at this edge (only issued when non-empty)
//     count_o      number of entries held (0..2)
//     head_o       oldest entry; zero after reset
module pattern_fifo2
    import pattern_fetch_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [1:0]        count_o,
    output logic [DATA_W-1:0] head_o
);

    logic [FIFO_DEPTH-1:0][DATA_W-1:0] slot_q;
    logic                              wr_q;
    logic                              rd_q;
    logic [1:0]                        count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            slot_q  <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push_i) begin
                slot_q[wr_q] <= push_data_i;
                wr_q         <= ~wr_q;
            end
            if (pop_i) begin
                rd_q <= ~rd_q;
            end
            // Simultaneous push and pop leave the occupancy unchanged.
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count_o = count_q;
    assign head_o  = slot_q[rd_q];

endmodule

// File: rtl/pattern_fetch.sv
// pattern_fetch
//   Walks the pattern memory from address 0 to LAST_ADDR and hands bytes to
//   the LED serializer over a valid/ready handshake. The memory has a
//   registered address, so a read issued in one cycle returns data in the
//   next; at most two bytes (buffered plus in flight) are ever outstanding,
//   which is what keeps the 2-entry buffer from overflowing.
//
//   Build option: define PATTERN_FETCH_LOOP_EN to keep fetching past
//   LAST_ADDR (wrapping to 0) until stop; otherwise a pass ends at LAST_ADDR.
//
//   Ports:
//     sys_clk     system clock
//     sys_rst_n   synchronous active-low reset
//     start       pulse; begins a pass from address 0 (ignored while busy)
//     stop        ends address issue early (ignored while idle)
//     mem_adr     registered address to the pattern memory
//     mem_dat_r   memory data, valid the cycle after mem_adr was sampled
//     byte_data   head-of-buffer byte
//     byte_valid  buffer non-empty
//     byte_ready  serializer accepts byte_data
//     busy        high while a pass is in progress
//     done        one-cycle pulse after the last byte is taken
module pattern_fetch
    import pattern_fetch_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] LAST_ADDR = '1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] mem_adr,
    input  logic [DATA_W-1:0] mem_dat_r,
    output logic [DATA_W-1:0] byte_data,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mem_adr_q, mem_adr_d;
    logic              pend_q;
    logic              done_q, done_d;
    logic              issue;
    logic              pop;
    logic [1:0]        fifo_count;
    logic [2:0]        in_flight;
    logic              at_last;

    assign byte_valid = (fifo_count != 2'd0);
    assign pop        = byte_valid && byte_ready;
    // Bytes still owed to the serializer once this cycle's pop is taken.
    assign in_flight  = {1'b0, fifo_count} + {2'b00, pend_q} - {2'b00, pop};
    assign at_last    = (mem_adr_q == LAST_ADDR);

    always_comb begin
        state_d   = state_q;
        mem_adr_d = mem_adr_q;
        done_d    = 1'b0;
        issue     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    mem_adr_d = '0;
                end
            end
            RUN: begin
                // stop wins over a read that would otherwise be issued.
                if (stop) begin
                    state_d = DRAIN;
                end else if (in_flight < 3'd2) begin
                    issue     = 1'b1;
                    mem_adr_d = at_last ? '0 : mem_adr_q + ADDR_W'(1);
`ifdef PATTERN_FETCH_LOOP_EN
                    state_d   = RUN;
`else
                    if (at_last) begin
                        state_d = DRAIN;
                    end
`endif
                end
            end
            DRAIN: begin
                if (!pend_q && in_flight == 3'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            mem_adr_q <= '0;
            pend_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_adr_q <= mem_adr_d;
            pend_q    <= issue;
            done_q    <= done_d;
        end
    end

    // Data for the read issued last cycle arrives now and is pushed.
    pattern_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk_i       (sys_clk),
        .rst_n_i     (sys_rst_n),
        .push_i      (pend_q),
        .push_data_i (mem_dat_r),
        .pop_i       (pop),
        .count_o     (fifo_count),
        .head_o      (byte_data)
    );

    assign mem_adr = mem_adr_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

endmodule

// File: tb/tb_pattern_fetch.sv
module tb_pattern_fetch;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n, start, stop, byte_ready;
    logic [7:0] mem_adr, mem_dat_r, byte_data;
    logic       byte_valid, busy, done;

    int checks = 0;
    int passed = 0;

    pattern_fetch #(
        .ADDR_W    (8),
        .DATA_W    (8),
        .LAST_ADDR (8'hFF)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .start      (start),
        .stop       (stop),
        .mem_adr    (mem_adr),
        .mem_dat_r  (mem_dat_r),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 sys_clk = ~sys_clk;

    // Pattern memory: registered address, mem[i] = i ^ A5.
    always @(posedge sys_clk) mem_dat_r <= mem_adr ^ 8'hA5;

    // Inputs are driven and outputs sampled 1 time unit after each edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        logic started;
        sys_rst_n = 1'b0; start = 1'b1; stop = 1'b0; byte_ready = 1'b1;
        repeat (3) tick();
        checks++; if (mem_adr !== 8'h00) $display("FAIL reset_mem_adr: got %0h want 0", mem_adr); else passed++;
        checks++; if (byte_data !== 8'h00) $display("FAIL reset_byte_data: got %0h want 0", byte_data); else passed++;
        checks++; if ({byte_valid, busy, done} !== 3'b000)
            $display("FAIL reset_flags: got valid/busy/done=%b want 000", {byte_valid, busy, done}); else passed++;
        sys_rst_n = 1'b1; start = 1'b0;
        started = 1'b0;
        repeat (8) begin
            tick();
            if (busy !== 1'b0 || byte_valid !== 1'b0 || done !== 1'b0) started = 1'b1;
        end
        checks++; if (started !== 1'b0) $display("FAIL reset_no_spurious_pass: got activity=1 want 0"); else passed++;
    endtask

`ifndef PATTERN_FETCH_LOOP_EN
    task automatic test_full_pass();
        int pops = 0, ndone = 0, first_v = -1, last_cyc = -1, done_cyc = -1;
        logic [7:0] expv;
        start = 1'b1; stop = 1'b0; byte_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < 400 && ndone == 0; cyc++) begin
            if (cyc == 1) begin
                checks++; if (busy !== 1'b1 || mem_adr !== 8'h00)
                    $display("FAIL full_cycle1: got busy=%b adr=%0h want busy=1 adr=0", busy, mem_adr); else passed++;
            end
            if (byte_valid === 1'b1 && first_v < 0) first_v = cyc;
            if (byte_valid === 1'b1) begin
                expv = 8'(pops) ^ 8'hA5;
                checks++; if (byte_data !== expv)
                    $display("FAIL full_byte%0d: got %0h want %0h", pops, byte_data, expv); else passed++;
                pops++;
                last_cyc = cyc;
            end
            if (done === 1'b1) begin ndone++; done_cyc = cyc; end
            tick();
        end
        checks++; if (first_v !== 3) $display("FAIL full_first_valid_cycle: got %0d want 3", first_v); else passed++;
        checks++; if (pops !== 256) $display("FAIL full_pop_count: got %0d want 256", pops); else passed++;
        checks++; if (last_cyc !== 258) $display("FAIL full_last_byte_cycle: got %0d want 258", last_cyc); else passed++;
        checks++; if (done_cyc !== 259) $display("FAIL full_done_cycle: got %0d want 259", done_cyc); else passed++;
        checks++; if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL full_done_pulse: got done=%b busy=%b want 0 0", done, busy); else passed++;
    endtask
`else
    task automatic test_loop();
        int pops = 0, ndone = 0;
        logic stopped = 1'b0;
        logic [7:0] expv, b255 = 8'h00, b256 = 8'h00;
        start = 1'b1; stop = 1'b0; byte_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < 1000 && ndone == 0; cyc++) begin
            stop = 1'b0;
            // After 600 pops, end issue at address 100 of the third lap: 612 reads.
            if (!stopped && pops >= 600 && mem_adr === 8'd100) begin stop = 1'b1; stopped = 1'b1; end
            if (byte_valid === 1'b1) begin
                expv = 8'(pops) ^ 8'hA5;
                checks++; if (byte_data !== expv)
                    $display("FAIL loop_byte%0d: got %0h want %0h", pops, byte_data, expv); else passed++;
                if (pops == 255) b255 = byte_data;
                if (pops == 256) b256 = byte_data;
                pops++;
            end
            if (done === 1'b1) ndone++;
            tick();
        end
        stop = 1'b0;
        checks++; if ({b255, b256} !== 16'h5AA5) $display("FAIL loop_wrap: got %0h want 5aa5", {b255, b256}); else passed++;
        checks++; if (pops !== 612) $display("FAIL loop_pop_count: got %0d want 612", pops); else passed++;
        checks++; if (ndone !== 1 || busy !== 1'b0)
            $display("FAIL loop_done: got done_count=%0d busy=%b want 1 0", ndone, busy); else passed++;
    endtask
`endif

    task automatic test_stop_mid();
        int pops = 0, ndone = 0, last_cyc = -1, done_cyc = -1;
        logic stopped = 1'b0;
        logic [7:0] expv;
        start = 1'b1; stop = 1'b0; byte_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < 200 && ndone == 0; cyc++) begin
            stop = 1'b0;
            if (!stopped && mem_adr === 8'd10) begin stop = 1'b1; stopped = 1'b1; end
            if (byte_valid === 1'b1) begin
                expv = 8'(pops) ^ 8'hA5;
                checks++; if (byte_data !== expv)
                    $display("FAIL stop_byte%0d: got %0h want %0h", pops, byte_data, expv); else passed++;
                pops++;
                last_cyc = cyc;
            end
            if (done === 1'b1) begin ndone++; done_cyc = cyc; end
            tick();
        end
        stop = 1'b0;
        checks++; if (pops !== 10) $display("FAIL stop_pop_count: got %0d want 10", pops); else passed++;
        checks++; if (done_cyc !== last_cyc + 1)
            $display("FAIL stop_done_cycle: got %0d want %0d", done_cyc, last_cyc + 1); else passed++;
        checks++; if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL stop_done_pulse: got done=%b busy=%b want 0 0", done, busy); else passed++;
    endtask

    task automatic test_backpressure();
        int pops = 0, ndone = 0, last_cyc = -1, done_cyc = -1;
        logic stopped = 1'b0, prev_hold = 1'b0;
        logic [7:0] expv, prev_data = 8'h00, ahead;
        start = 1'b1; stop = 1'b0; byte_ready = 1'b0;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < 3000 && ndone == 0; cyc++) begin
            stop = 1'b0;
            byte_ready = ($urandom_range(0, 99) < 30);
            if (!stopped && mem_adr === 8'd60) begin stop = 1'b1; stopped = 1'b1; end
            if (prev_hold) begin
                checks++; if (byte_valid !== 1'b1 || byte_data !== prev_data)
                    $display("FAIL bp_stable: got valid=%b data=%0h want 1 %0h", byte_valid, byte_data, prev_data); else passed++;
            end
            if (busy === 1'b1) begin
                ahead = mem_adr - 8'(pops);
                checks++; if (ahead > 8'd2)
                    $display("FAIL bp_ahead: got %0d want <=2", ahead); else passed++;
            end
            prev_hold = (byte_valid === 1'b1) && !byte_ready;
            prev_data = byte_data;
            if (byte_valid === 1'b1 && byte_ready) begin
                expv = 8'(pops) ^ 8'hA5;
                checks++; if (byte_data !== expv)
                    $display("FAIL bp_byte%0d: got %0h want %0h", pops, byte_data, expv); else passed++;
                pops++;
                last_cyc = cyc;
            end
            if (done === 1'b1) begin ndone++; done_cyc = cyc; end
            tick();
        end
        stop = 1'b0; byte_ready = 1'b1;
        checks++; if (pops !== 60) $display("FAIL bp_pop_count: got %0d want 60", pops); else passed++;
        checks++; if (done_cyc !== last_cyc + 1)
            $display("FAIL bp_done_cycle: got %0d want %0d", done_cyc, last_cyc + 1); else passed++;
    endtask

    task automatic test_reset_mid();
        int pops = 0, ndone = 0, first_v = -1;
        logic stopped = 1'b0, leak = 1'b0;
        logic [7:0] expv;
        start = 1'b1; stop = 1'b0; byte_ready = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick();
        // Cycle 3: one byte buffered, a second read in flight.
        checks++; if (byte_valid !== 1'b1 || mem_adr !== 8'd2 || busy !== 1'b1)
            $display("FAIL rmid_pre_state: got valid=%b adr=%0h busy=%b want 1 2 1", byte_valid, mem_adr, busy); else passed++;
        sys_rst_n = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        checks++; if (byte_valid !== 1'b0 || busy !== 1'b0 || mem_adr !== 8'd0)
            $display("FAIL rmid_cleared: got valid=%b busy=%b adr=%0h want 0 0 0", byte_valid, busy, mem_adr); else passed++;
        repeat (3) begin
            tick();
            if (byte_valid !== 1'b0 || busy !== 1'b0) leak = 1'b1;
        end
        checks++; if (leak !== 1'b0) $display("FAIL rmid_discard: got activity=1 want 0"); else passed++;
        start = 1'b1; byte_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < 200 && ndone == 0; cyc++) begin
            stop = 1'b0;
            if (!stopped && mem_adr === 8'd5) begin stop = 1'b1; stopped = 1'b1; end
            if (byte_valid === 1'b1 && first_v < 0) first_v = cyc;
            if (byte_valid === 1'b1) begin
                expv = 8'(pops) ^ 8'hA5;
                checks++; if (byte_data !== expv)
                    $display("FAIL rmid_byte%0d: got %0h want %0h", pops, byte_data, expv); else passed++;
                pops++;
            end
            if (done === 1'b1) ndone++;
            tick();
        end
        stop = 1'b0;
        checks++; if (first_v !== 3) $display("FAIL rmid_first_valid_cycle: got %0d want 3", first_v); else passed++;
        checks++; if (pops !== 5 || ndone !== 1)
            $display("FAIL rmid_pass_end: got pops=%0d done_count=%0d want 5 1", pops, ndone); else passed++;
    endtask

    initial begin
        sys_rst_n = 1'b0; start = 1'b0; stop = 1'b0; byte_ready = 1'b0;
        #1;
        test_reset();
`ifndef PATTERN_FETCH_LOOP_EN
        test_full_pass();
`else
        test_loop();
`endif
        test_stop_mid();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, checks);
        $fatal(1);
    end

endmodule
